// File: rtl/move_sequencer_if.sv
// Request/step bundle between requesters and the move sequencer.
interface move_sequencer_if;
  logic [3:0]  req;
  logic [11:0] len;
  logic        move;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        busy;
  logic [7:0]  pos;
  logic [2:0]  remaining;

  modport master (
    output req, len,
    input  move, grant, done, busy, pos, remaining
  );

  modport slave (
    input  req, len,
    output move, grant, done, busy, pos, remaining
  );
endinterface

// File: rtl/move_sequencer.sv
// Round-robin arbiter issuing step bursts to a 5-position step machine,
// with configurable idle gap between pulses and a wrap stall at position 4.
module move_sequencer #(
  parameter int unsigned STEP_GAP = 1
) (
  input logic            clk,
  input logic            rst,
  move_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, STEP, GAP, DONE} state_t;

  localparam logic [3:0] GAP_LOAD = (STEP_GAP == 0) ? 4'd0 : 4'(STEP_GAP - 1);

  state_t     state, state_nx;
  logic [1:0] ptr, ptr_nx;
  logic [3:0] gap_cnt, gap_nx;
  logic [2:0] rem, rem_nx;
  logic [3:0] grant_r, grant_nx;
  logic [3:0] done_r, done_nx;
  logic       move_r, move_nx;
  logic       busy_r;
  logic [7:0] pos_r, pos_nx;

  logic       found;
  logic [1:0] pick, idx;
  logic [2:0] lsel;
  logic       issue;

  // pos_nx is also the position seen by the pulse issued at this edge,
  // so gating on it keeps move and pos==4 from ever coinciding.
  always_comb begin
    if (pos_r == 8'd4)
      pos_nx = '0;
    else if (move_r)
      pos_nx = pos_r + 8'd1;
    else
      pos_nx = pos_r;
  end

  assign issue = (state == STEP) && (pos_nx != 8'd4);

  always_comb begin
    found = 1'b0;
    pick  = ptr;
    idx   = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = ptr + i[1:0];
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    case (pick)
      2'd0:    lsel = bus.len[2:0];
      2'd1:    lsel = bus.len[5:3];
      2'd2:    lsel = bus.len[8:6];
      default: lsel = bus.len[11:9];
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      ptr     <= '0;
      gap_cnt <= '0;
      rem     <= '0;
      grant_r <= '0;
      done_r  <= '0;
      move_r  <= 1'b0;
      busy_r  <= 1'b0;
      pos_r   <= '0;
    end else begin
      state   <= state_nx;
      ptr     <= ptr_nx;
      gap_cnt <= gap_nx;
      rem     <= rem_nx;
      grant_r <= grant_nx;
      done_r  <= done_nx;
      move_r  <= move_nx;
      busy_r  <= (state_nx != IDLE);
      pos_r   <= pos_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (found) state_nx = STEP;
      STEP: begin
        if (issue) begin
          if (rem == 3'd1)
            state_nx = DONE;
          else if (STEP_GAP != 0)
            state_nx = GAP;
          else
            state_nx = STEP;
        end
      end
      GAP:  if (gap_cnt == '0) state_nx = STEP;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    ptr_nx   = ptr;
    gap_nx   = gap_cnt;
    rem_nx   = rem;
    grant_nx = grant_r;
    done_nx  = '0;
    move_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          grant_nx = 4'b0001 << pick;
          rem_nx   = (lsel == 3'd0) ? 3'd1 : lsel;
          ptr_nx   = pick + 2'd1;
        end
      end
      STEP: begin
        if (issue) begin
          move_nx = 1'b1;
          rem_nx  = rem - 3'd1;
          if (rem != 3'd1) gap_nx = GAP_LOAD;
        end
      end
      GAP: begin
        if (gap_cnt != '0) gap_nx = gap_cnt - 4'd1;
      end
      DONE: begin
        done_nx  = grant_r;
        grant_nx = '0;
      end
      default: ;
    endcase
  end

  assign bus.move      = move_r;
  assign bus.grant     = grant_r;
  assign bus.done      = done_r;
  assign bus.busy      = busy_r;
  assign bus.pos       = pos_r;
  assign bus.remaining = rem;

endmodule

// File: tb/tb_move_sequencer.sv
// Checks two sequencers (gap 1 and gap 0) against a burst-timeline model.
module tb_move_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [11:0] len;

  int checks = 0;
  int fails  = 0;

  logic       o_move  [2];
  logic [3:0] o_grant [2];
  logic [3:0] o_done  [2];
  logic       o_busy  [2];
  logic [7:0] o_pos   [2];
  logic [2:0] o_rem   [2];

  typedef struct packed {
    logic       move;
    logic [2:0] rem;
    logic [3:0] grant;
    logic       busy;
    logic [3:0] done;
  } exp_t;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int GAPV = (g == 0) ? 1 : 0;

    move_sequencer_if bus ();
    move_sequencer #(.STEP_GAP(GAPV)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    assign bus.req    = req;
    assign bus.len    = len;
    assign o_move[g]  = bus.move;
    assign o_grant[g] = bus.grant;
    assign o_done[g]  = bus.done;
    assign o_busy[g]  = bus.busy;
    assign o_pos[g]   = bus.pos;
    assign o_rem[g]   = bus.remaining;

    // Expected per-cycle outputs of the burst in flight, one entry per cycle.
    exp_t       plan[$];
    exp_t       cur;
    int         pos_m = 0;
    int         ptr_m = 0;
    bit         valid = 0;
    logic [3:0] prev_grant = '0;

    always @(negedge clk) begin
      int pn, k, n, p, mprev, r, wt, mv;
      logic [3:0] gb;
      cur = (plan.size() > 0) ? plan.pop_front() : '0;
      if (valid) begin
        check($sformatf("lane%0d outputs", g),
              32'({bus.move, bus.remaining, bus.grant, bus.busy, bus.done, bus.pos}),
              32'({cur.move, cur.rem, cur.grant, cur.busy, cur.done, 8'(pos_m)}));
        check($sformatf("lane%0d invariants", g),
              32'((bus.pos <= 8'd4) && !(bus.move && bus.pos == 8'd4) &&
                  $onehot0(bus.grant) && ((bus.done & ~prev_grant) == 4'b0)),
              32'd1);
      end
      prev_grant = bus.grant;
      if (!rst) begin
        plan.delete();
        pos_m = 0;
        ptr_m = 0;
        valid = 1;
      end else if (valid) begin
        pn = (pos_m == 4) ? 0 : pos_m + int'(cur.move);
        if (plan.size() == 0 && req != 4'b0) begin
          k = ptr_m;
          for (int i = 0; i < 4; i++) begin
            if (req[(ptr_m + i) % 4]) begin
              k = (ptr_m + i) % 4;
              break;
            end
          end
          ptr_m = (k + 1) % 4;
          n = int'((len >> (3 * k)) & 12'd7);
          if (n == 0) n = 1;
          gb = 4'b0001 << k;
          plan.push_back({1'b0, 3'(n), gb, 1'b1, 4'b0});
          p = pn; mprev = 0; r = n; wt = 0;
          while (r > 0) begin
            int px;
            px = (p == 4) ? 0 : p + mprev;
            if (wt > 0) begin
              wt--; mv = 0;
            end else if (px == 4) begin
              mv = 0;
            end else begin
              r--; mv = 1; wt = GAPV;
            end
            plan.push_back({mv[0], 3'(r), gb, 1'b1, 4'b0});
            p = px; mprev = mv;
          end
          plan.push_back({1'b0, 3'd0, 4'b0, 1'b0, gb});
        end
        pos_m = pn;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [6:0] mvv, dnv;
    logic [4:0] mv1;
    logic [7:0] pv [5];
    logic [3:0] gl [5];
    logic [3:0] prevg;
    int n, dcount, nm, to;
    bit seen;

    rst = 1'b0; req = '0; len = '0;
    repeat (3) tick();
    check("reset outputs", 32'({o_move[0], o_grant[0], o_done[0], o_busy[0], o_pos[0], o_rem[0]}), 32'd0);
    rst = 1'b1;
    tick();

    // single burst, gap 1
    len = 12'o0003; req = 4'b0001;
    tick();
    req = '0;
    check("burst grant", 32'(o_grant[0]), 32'd1);
    check("burst remaining", 32'(o_rem[0]), 32'd3);
    mvv = '0; dnv = '0;
    for (int i = 0; i < 7; i++) begin
      tick();
      mvv[i] = o_move[0];
      dnv[i] = (o_done[0] == 4'b0001);
    end
    check("burst move pattern", 32'(mvv), 32'b0010101);
    check("burst done pattern", 32'(dnv), 32'b0100000);
    check("burst end pos", 32'(o_pos[0]), 32'd3);
    check("burst end busy", 32'(o_busy[0]), 32'd0);
    repeat (4) tick();

    // wrap stall on gap-0 lane starting at pos 3
    check("wrap start pos", 32'(o_pos[1]), 32'd3);
    len = 12'o0003; req = 4'b0001;
    tick();
    req = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      mv1[i] = o_move[1];
      pv[i]  = o_pos[1];
    end
    check("wrap move pattern", 32'(mv1), 32'b01101);
    check("wrap stall pos", 32'(pv[1]), 32'd4);
    check("wrap restart pos", 32'(pv[2]), 32'd0);
    check("wrap end pos", 32'(pv[4]), 32'd2);
    repeat (5) tick();

    // round-robin fairness from a fresh pointer
    rst = 1'b0;
    tick();
    rst = 1'b1; len = 12'o1111; req = 4'hf;
    prevg = '0; n = 0; dcount = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (o_grant[0] != 4'b0 && prevg == 4'b0 && n < 5) begin
        gl[n] = o_grant[0];
        n++;
      end
      if (o_done[0] != 4'b0) dcount++;
      prevg = o_grant[0];
    end
    req = '0;
    check("rr grant count", 32'(n), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < n) check($sformatf("rr grant %0d", i), 32'(gl[i]), 32'(4'b0001 << (i % 4)));
    check("rr done count", 32'(dcount), 32'd5);
    repeat (6) tick();

    // len 0 behaves as a single step
    len = 12'o0000; req = 4'b0100;
    tick();
    req = '0;
    check("len0 grant", 32'(o_grant[0]), 32'h4);
    nm = 0; dcount = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (o_move[0]) nm++;
      if (o_done[0] == 4'b0100) dcount++;
    end
    check("len0 moves", 32'(nm), 32'd1);
    check("len0 done", 32'(dcount), 32'd1);

    // reset after the second move of a 5-step burst
    len = 12'o0005; req = 4'b0001;
    tick();
    req = '0;
    nm = 0; to = 0;
    while (nm < 2 && to < 20) begin
      tick();
      if (o_move[0]) nm++;
      to++;
    end
    check("midreset reached 2nd move", 32'(nm), 32'd2);
    rst = 1'b0;
    #1;
    check("reset waits for edge", 32'(o_move[0]), 32'd1);
    tick();
    check("midreset outputs", 32'({o_move[0], o_grant[0], o_done[0], o_busy[0], o_pos[0], o_rem[0]}), 32'd0);
    rst = 1'b1;
    dcount = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (o_done[0] != 4'b0) dcount++;
    end
    check("midreset no done", 32'(dcount), 32'd0);
    len = 12'o0001; req = 4'b0001;
    tick();
    req = '0;
    check("post-reset grant", 32'(o_grant[0]), 32'd1);
    repeat (6) tick();

    // requester drops req one cycle after grant
    len = 12'o0040; req = 4'b0010;
    tick();
    check("late drop grant", 32'(o_grant[0]), 32'h2);
    nm = 0; seen = 0; to = 0;
    while (!seen && to < 30) begin
      tick();
      req = '0;
      if (o_move[0]) nm++;
      if (o_done[0] == 4'b0010) seen = 1;
      to++;
    end
    check("late drop moves", 32'(nm), 32'd4);
    check("late drop done", 32'(seen), 32'd1);
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
